prbs_checker: RTL and testbench

//  Receive-side partner of LFSR: takes the serial pseudo-random bit stream an LFSR emits
//  (one bit per en_i beat), self-synchronises a local reference to it, then flags and

---
 rtl/prbs_checker.sv | 137 +++++++++++++
 tb/tb_prbs_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills a history register from the received stream,
// hunts for a run of correct predictions, then free-runs the reference and counts bit errors.
module prbs_checker #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] TAPS        = 16'hB400,
  parameter int               LOCK_CNT    = 32,
  parameter int               LOSS_THRESH = 8,
  parameter int               CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic [1:0]       state_o
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_THRESH + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'b00,
    S_HUNT = 2'b01,
    S_LOCK = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_h;
  logic [FW-1:0]    r_fill;
  logic [GW-1:0]    r_good;
  logic [BW-1:0]    r_bad;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_bit_cnt;

  logic             w_p;
  logic             w_miss;
  logic             w_hz;
  logic [CNT_W-1:0] w_err_base;
  logic [CNT_W-1:0] w_bit_base;
  logic [CNT_W-1:0] w_err_inc;
  logic [CNT_W-1:0] w_bit_inc;

  assign w_p    = ^(r_h & TAPS);
  assign w_miss = bit_i ^ w_p;
  assign w_hz   = (r_h == '0);

  // Clear is applied before the same-beat increment, so a clear on an error beat leaves 1.
  assign w_err_base = clr_i ? '0 : r_err_cnt;
  assign w_bit_base = clr_i ? '0 : r_bit_cnt;
  assign w_err_inc  = (&w_err_base) ? w_err_base : w_err_base + CNT_W'(1);
  assign w_bit_inc  = (&w_bit_base) ? w_bit_base : w_bit_base + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_FILL;
      r_h       <= '0;
      r_fill    <= '0;
      r_good    <= '0;
      r_bad     <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_err     <= 1'b0;
      r_err_cnt <= w_err_base;
      r_bit_cnt <= w_bit_base;
      if (en_i) begin
        case (r_state)
          S_FILL: begin
            r_h    <= {r_h[WIDTH-2:0], bit_i};
            r_good <= '0;
            if (r_fill == FILL_LAST) begin
              r_fill  <= '0;
              r_state <= S_HUNT;
            end else begin
              r_fill <= r_fill + FW'(1);
            end
          end
          S_HUNT: begin
            r_h <= {r_h[WIDTH-2:0], bit_i};
            // An all-zero history predicts zeros forever, so it must never count as good.
            if (!w_miss && !w_hz) begin
              if (r_good == GOOD_LAST) begin
                r_good   <= '0;
                r_bad    <= '0;
                r_state  <= S_LOCK;
                r_locked <= 1'b1;
              end else begin
                r_good <= r_good + GW'(1);
              end
            end else begin
              r_good <= '0;
            end
          end
          S_LOCK: begin
            // Reference free-runs so a channel bit error is not fed back into predictions.
            r_h       <= {r_h[WIDTH-2:0], w_p};
            r_bit_cnt <= w_bit_inc;
            if (w_miss) begin
              r_err     <= 1'b1;
              r_err_cnt <= w_err_inc;
              if (r_bad == BAD_LAST) begin
                r_bad    <= '0;
                r_fill   <= '0;
                r_state  <= S_FILL;
                r_locked <= 1'b0;
              end else begin
                r_bad <= r_bad + BW'(1);
              end
            end else begin
              r_bad <= '0;
            end
          end
          default: r_state <= S_FILL;
        endcase
      end
    end
  end

  assign locked_o  = r_locked;
  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;
  assign bit_cnt_o = r_bit_cnt;
  assign state_o   = r_state;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: an LFSR stream (seed 16'hACE1) drives a default
// instance and a 4-bit-counter instance side by side.
module tb_prbs_checker;

  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, bit_i, clr_i;
  logic        locked_o, err_o;
  logic [15:0] err_cnt_o, bit_cnt_o;
  logic [1:0]  state_o;
  logic        s_locked, s_err;
  logic [3:0]  s_err_cnt, s_bit_cnt;
  logic [1:0]  s_state;

  logic [15:0] g;
  logic        zero_mode;
  logic        saw_lock;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_i = ~clk_i;

  prbs_checker u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .bit_i(bit_i), .clr_i(clr_i),
    .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
    .bit_cnt_o(bit_cnt_o), .state_o(state_o)
  );

  prbs_checker #(.CNT_W(4)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .bit_i(bit_i), .clr_i(clr_i),
    .locked_o(s_locked), .err_o(s_err), .err_cnt_o(s_err_cnt),
    .bit_cnt_o(s_bit_cnt), .state_o(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the LFSR on valid beats, optionally corrupt the bit, sample 1ns after the edge.
  task automatic beat(input logic en, input logic flip, input logic clr);
    logic nb;
    if (en) begin
      nb    = zero_mode ? 1'b0 : ^(g & TAPS);
      g     = {g[14:0], nb};
      bit_i = nb ^ flip;
    end else begin
      bit_i = 1'b1;
    end
    en_i  = en;
    clr_i = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, locked_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_errcnt"}, err_cnt_o, 0);
    chk({tag, "_bitcnt"}, bit_cnt_o, 0);
    chk({tag, "_state"}, state_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; bit_i = 1'b0; clr_i = 1'b0;
    g = 16'hACE1; zero_mode = 1'b0; saw_lock = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_zero("reset");
    rst_i = 1'b0;

    // Clean stream: lock visible right after beat 48, then 952 locked beats
    for (int i = 1; i <= 1000; i++) begin
      beat(1, 0, 0);
      if (i == 15) chk("fill_state_b15", state_o, 0);
      if (i == 16) chk("hunt_state_b16", state_o, 1);
      if (i == 47) chk("unlocked_b47", locked_o, 0);
      if (i == 48) begin
        chk("locked_b48", locked_o, 1);
        chk("lock_state_b48", state_o, 2);
      end
    end
    chk("clean_errcnt", err_cnt_o, 0);
    chk("clean_bitcnt", bit_cnt_o, 952);
    chk("sat_bitcnt", s_bit_cnt, 15);

    // Single bit error
    beat(1, 1, 0);
    chk("single_err_pulse", err_o, 1);
    chk("single_errcnt", err_cnt_o, 1);
    chk("single_locked", locked_o, 1);
    beat(1, 0, 0);
    chk("single_err_drop", err_o, 0);
    chk("single_still_locked", locked_o, 1);
    chk("single_bitcnt", bit_cnt_o, 954);

    // Clear on an idle cycle, then 8 consecutive errors force relock
    beat(0, 0, 1);
    chk("clr_errcnt", err_cnt_o, 0);
    chk("clr_bitcnt", bit_cnt_o, 0);
    chk("clr_keeps_lock", locked_o, 1);
    for (int k = 1; k <= 8; k++) begin
      beat(1, 1, 0);
      if (k == 7) chk("burst7_locked", locked_o, 1);
    end
    chk("burst_errcnt", err_cnt_o, 8);
    chk("burst_unlocked", locked_o, 0);
    chk("burst_state", state_o, 0);
    chk("burst_bitcnt", bit_cnt_o, 8);
    for (int i = 1; i <= 48; i++) begin
      beat(1, 0, 0);
      if (i == 47) chk("relock_b47", locked_o, 0);
      if (i == 48) chk("relock_b48", locked_o, 1);
    end
    chk("relock_errcnt_hold", err_cnt_o, 8);

    // Mid-lock reset, then en_i one cycle in three
    rst_i = 1'b1;
    beat(1, 1, 0);
    rst_i = 1'b0;
    chk_zero("midreset1");
    for (int i = 1; i <= 48; i++) begin
      beat(0, 0, 0);
      beat(0, 0, 0);
      beat(1, 0, 0);
      if (i == 47) chk("sparse_b47", locked_o, 0);
      if (i == 48) chk("sparse_b48", locked_o, 1);
    end
    beat(1, 0, 0);
    chk("sparse_bitcnt", bit_cnt_o, 1);
    repeat (3) beat(0, 0, 0);
    chk("idle_bitcnt", bit_cnt_o, 1);
    chk("idle_err", err_o, 0);
    chk("idle_locked", locked_o, 1);

    // Stuck-at-zero stream never locks
    rst_i = 1'b1;
    beat(0, 0, 0);
    rst_i = 1'b0;
    zero_mode = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      beat(1, 0, 0);
      saw_lock = saw_lock | locked_o;
      if (i == 16) chk("zero_hunt_b16", state_o, 1);
    end
    chk("zero_never_locked", saw_lock, 0);
    chk("zero_state", state_o, 1);

    // Clear on an error beat, then counter saturation
    rst_i = 1'b1;
    beat(0, 0, 0);
    rst_i = 1'b0;
    zero_mode = 1'b0;
    g = 16'hACE1;
    repeat (48) beat(1, 0, 0);
    chk("t6_locked", locked_o, 1);
    repeat (2) beat(1, 0, 0);
    beat(1, 1, 1);
    chk("clr_err_errcnt", err_cnt_o, 1);
    chk("clr_err_bitcnt", bit_cnt_o, 1);
    chk("clr_err_pulse", err_o, 1);
    for (int k = 0; k < 16; k++) begin
      beat(1, 1, 0);
      beat(1, 0, 0);
    end
    chk("sat_errcnt", s_err_cnt, 15);
    chk("sat_locked", s_locked, 1);
    chk("wide_errcnt", err_cnt_o, 17);
    chk("wide_bitcnt", bit_cnt_o, 33);
    chk("alt_locked", locked_o, 1);

    rst_i = 1'b1;
    beat(1, 1, 1);
    rst_i = 1'b0;
    chk_zero("midreset2");
    chk("midreset2_sat_errcnt", s_err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
